// File: rtl/ls_ex_pkg.sv
// Shared load/store definitions: opnum encodings, ROB tag constants, common types
// and a length-to-byte-mask helper.
package ls_ex_pkg;

    localparam logic [5:0] OPNUM_LB  = 6'd0;
    localparam logic [5:0] OPNUM_LH  = 6'd1;
    localparam logic [5:0] OPNUM_LW  = 6'd2;
    localparam logic [5:0] OPNUM_LBU = 6'd3;
    localparam logic [5:0] OPNUM_LHU = 6'd4;
    localparam logic [5:0] OPNUM_SB  = 6'd5;
    localparam logic [5:0] OPNUM_SH  = 6'd6;
    localparam logic [5:0] OPNUM_SW  = 6'd7;

    localparam int INVALID_ROB = 0;

    typedef logic [31:0] DATA_TYPE;
    typedef logic [31:0] ADDR_TYPE;
    typedef logic [3:0]  ROB_ID_TYPE;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_MC = 1'b1
    } ls_ex_state_t;

    // Keeps only the bytes covered by an access of the given length.
    function automatic DATA_TYPE len_mask(input logic [2:0] len);
        case (len)
            3'd1:    len_mask = 32'h0000_00FF;
            3'd2:    len_mask = 32'h0000_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ls_ex_extend.sv
// Combinational opnum decode: access length in bytes and sign/zero extension of
// right-justified load data. Shared with the LS buffer's store-length logic.
module ls_ex_extend
    import ls_ex_pkg::*;
#(
    parameter int OPNUM_WIDTH = 6
) (
    input  logic [OPNUM_WIDTH-1:0] opnum,
    input  DATA_TYPE               raw_data,
    output DATA_TYPE               ext_data,
    output logic [2:0]             len
);

    // Decode length and extension per opnum; unknown codes pass data as a word.
    always_comb begin
        ext_data = raw_data;
        len      = 3'd4;
        case (opnum)
            OPNUM_WIDTH'(OPNUM_LB): begin
                ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
                len      = 3'd1;
            end
            OPNUM_WIDTH'(OPNUM_LH): begin
                ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
                len      = 3'd2;
            end
            OPNUM_WIDTH'(OPNUM_LBU): begin
                ext_data = {24'h00_0000, raw_data[7:0]};
                len      = 3'd1;
            end
            OPNUM_WIDTH'(OPNUM_LHU): begin
                ext_data = {16'h0000, raw_data[15:0]};
                len      = 3'd2;
            end
            OPNUM_WIDTH'(OPNUM_SB): len = 3'd1;
            OPNUM_WIDTH'(OPNUM_SH): len = 3'd2;
            default: begin
                ext_data = raw_data;
                len      = 3'd4;
            end
        endcase
    end

endmodule

// File: rtl/ls_ex.sv
// Load/store execution unit: one outstanding memory op, load results broadcast on
// the LS result bus. Optional performance counters under LS_EX_PERF_CNT_EN.
module ls_ex
    import ls_ex_pkg::*;
#(
    parameter int ROB_ID_WIDTH = 4,
    parameter int OPNUM_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    enable_sign_from_ls,
    input  logic [OPNUM_WIDTH-1:0]  opnum_from_ls,
    input  ADDR_TYPE                addr_from_ls,
    input  DATA_TYPE                store_data_from_ls,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_ls,
    output logic                    full_sign_to_ls,
    input  logic                    rollback_sign_from_rob,
    output logic                    enable_sign_to_mc,
    output logic                    wr_sign_to_mc,
    output ADDR_TYPE                addr_to_mc,
    output DATA_TYPE                data_to_mc,
    output logic [2:0]              len_to_mc,
    input  logic                    valid_sign_from_mc,
    input  DATA_TYPE                data_from_mc,
    output logic                    valid_sign_to_cdb,
    output logic [ROB_ID_WIDTH-1:0] rob_id_to_cdb,
    output DATA_TYPE                data_to_cdb
`ifdef LS_EX_PERF_CNT_EN
    ,
    output logic [31:0]             load_cnt_out,
    output logic [31:0]             store_cnt_out,
    output logic [31:0]             stall_cnt_out
`endif
);

    ls_ex_state_t            state_r;
    logic                    discard_r;
    logic                    wr_r;
    logic [OPNUM_WIDTH-1:0]  opnum_r;
    logic [ROB_ID_WIDTH-1:0] rob_id_r;

    logic                    iss_is_load_s;
    logic [2:0]              iss_len_s;
    DATA_TYPE                iss_ext_unused_s;
    DATA_TYPE                cmp_data_s;
    logic [2:0]              cmp_len_unused_s;
    logic                    accept_s;
    logic                    complete_s;
    logic                    broadcast_s;
    logic                    store_done_s;

    ls_ex_extend #(.OPNUM_WIDTH(OPNUM_WIDTH)) u_iss_ext (
        .opnum    (opnum_from_ls),
        .raw_data (store_data_from_ls),
        .ext_data (iss_ext_unused_s),
        .len      (iss_len_s)
    );

    ls_ex_extend #(.OPNUM_WIDTH(OPNUM_WIDTH)) u_cmp_ext (
        .opnum    (opnum_r),
        .raw_data (data_from_mc),
        .ext_data (cmp_data_s),
        .len      (cmp_len_unused_s)
    );

    assign iss_is_load_s   = (opnum_from_ls <= OPNUM_WIDTH'(OPNUM_LHU));
    assign full_sign_to_ls = (state_r != ST_IDLE);
    // A load issued under rollback belongs to the flushed path and is dropped.
    assign accept_s     = (state_r == ST_IDLE) && enable_sign_from_ls &&
                          !(rollback_sign_from_rob && iss_is_load_s);
    assign complete_s   = (state_r == ST_WAIT_MC) && valid_sign_from_mc;
    assign broadcast_s  = complete_s && !wr_r && !discard_r && !rollback_sign_from_rob;
    assign store_done_s = complete_s && wr_r;

    // Issue/complete FSM with registered memory-controller and result-bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            discard_r         <= 1'b0;
            wr_r              <= 1'b0;
            opnum_r           <= {OPNUM_WIDTH{1'b0}};
            rob_id_r          <= {ROB_ID_WIDTH{1'b0}};
            enable_sign_to_mc <= 1'b0;
            wr_sign_to_mc     <= 1'b0;
            addr_to_mc        <= 32'h0000_0000;
            data_to_mc        <= 32'h0000_0000;
            len_to_mc         <= 3'd0;
            valid_sign_to_cdb <= 1'b0;
            rob_id_to_cdb     <= ROB_ID_WIDTH'(INVALID_ROB);
            data_to_cdb       <= 32'h0000_0000;
        end else if (rdy) begin
            enable_sign_to_mc <= 1'b0;
            valid_sign_to_cdb <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r           <= ST_WAIT_MC;
                        discard_r         <= 1'b0;
                        wr_r              <= !iss_is_load_s;
                        opnum_r           <= opnum_from_ls;
                        rob_id_r          <= rob_id_from_ls;
                        enable_sign_to_mc <= 1'b1;
                        wr_sign_to_mc     <= !iss_is_load_s;
                        addr_to_mc        <= addr_from_ls;
                        len_to_mc         <= iss_len_s;
                        data_to_mc        <= store_data_from_ls & len_mask(iss_len_s);
                    end
                end
                ST_WAIT_MC: begin
                    if (complete_s) begin
                        state_r   <= ST_IDLE;
                        discard_r <= 1'b0;
                        if (broadcast_s) begin
                            valid_sign_to_cdb <= 1'b1;
                            rob_id_to_cdb     <= rob_id_r;
                            data_to_cdb       <= cmp_data_s;
                        end
                    end else if (rollback_sign_from_rob && !wr_r) begin
                        discard_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef LS_EX_PERF_CNT_EN
    // Wrapping event counters: broadcast loads, completed stores, busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_out  <= 32'd0;
            store_cnt_out <= 32'd0;
            stall_cnt_out <= 32'd0;
        end else if (rdy) begin
            if (broadcast_s) load_cnt_out <= load_cnt_out + 32'd1;
            if (store_done_s) store_cnt_out <= store_cnt_out + 32'd1;
            if (state_r == ST_WAIT_MC) stall_cnt_out <= stall_cnt_out + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ls_ex.sv
// Directed bench for ls_ex: expected memory requests and result-bus broadcasts
// are queued as stimulus is driven and checked by a monitor as the DUT emits them.
module tb_ls_ex;
    import ls_ex_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } mc_req_t;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] data;
    } cdb_res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        enable_sign_from_ls = 1'b0;
    logic [5:0]  opnum_from_ls = 6'd0;
    logic [31:0] addr_from_ls = 32'd0;
    logic [31:0] store_data_from_ls = 32'd0;
    logic [3:0]  rob_id_from_ls = 4'd0;
    logic        full_sign_to_ls;
    logic        rollback_sign_from_rob = 1'b0;
    logic        enable_sign_to_mc;
    logic        wr_sign_to_mc;
    logic [31:0] addr_to_mc;
    logic [31:0] data_to_mc;
    logic [2:0]  len_to_mc;
    logic        valid_sign_from_mc = 1'b0;
    logic [31:0] data_from_mc = 32'd0;
    logic        valid_sign_to_cdb;
    logic [3:0]  rob_id_to_cdb;
    logic [31:0] data_to_cdb;

    int n_cmp = 0;
    int n_err = 0;
    mc_req_t  mc_q[$];
    cdb_res_t cdb_q[$];

    ls_ex dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .enable_sign_from_ls    (enable_sign_from_ls),
        .opnum_from_ls          (opnum_from_ls),
        .addr_from_ls           (addr_from_ls),
        .store_data_from_ls     (store_data_from_ls),
        .rob_id_from_ls         (rob_id_from_ls),
        .full_sign_to_ls        (full_sign_to_ls),
        .rollback_sign_from_rob (rollback_sign_from_rob),
        .enable_sign_to_mc      (enable_sign_to_mc),
        .wr_sign_to_mc          (wr_sign_to_mc),
        .addr_to_mc             (addr_to_mc),
        .data_to_mc             (data_to_mc),
        .len_to_mc              (len_to_mc),
        .valid_sign_from_mc     (valid_sign_from_mc),
        .data_from_mc           (data_from_mc),
        .valid_sign_to_cdb      (valid_sign_to_cdb),
        .rob_id_to_cdb          (rob_id_to_cdb),
        .data_to_cdb            (data_to_cdb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mc(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
        mc_req_t r;
        r.wr = wr; r.addr = a; r.data = d; r.len = len;
        mc_q.push_back(r);
    endtask

    task automatic push_cdb(input logic [3:0] rob, input logic [31:0] d);
        cdb_res_t r;
        r.rob = rob; r.data = d;
        cdb_q.push_back(r);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [3:0] rob);
        enable_sign_from_ls = 1'b1;
        opnum_from_ls       = op;
        addr_from_ls        = a;
        store_data_from_ls  = sd;
        rob_id_from_ls      = rob;
        tick();
        enable_sign_from_ls = 1'b0;
    endtask

    task automatic mc_done(input logic [31:0] d);
        valid_sign_from_mc = 1'b1;
        data_from_mc       = d;
        tick();
        valid_sign_from_mc = 1'b0;
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (enable_sign_to_mc) begin
                if (mc_q.size() == 0) begin
                    chk("mc_unexpected", 32'd1, 32'd0);
                end else begin
                    mc_req_t e;
                    e = mc_q.pop_front();
                    chk("mc_wr", {31'd0, wr_sign_to_mc}, {31'd0, e.wr});
                    chk("mc_addr", addr_to_mc, e.addr);
                    chk("mc_data", data_to_mc, e.data);
                    chk("mc_len", {29'd0, len_to_mc}, {29'd0, e.len});
                end
            end
            if (valid_sign_to_cdb) begin
                if (cdb_q.size() == 0) begin
                    chk("cdb_unexpected", 32'd1, 32'd0);
                end else begin
                    cdb_res_t e;
                    e = cdb_q.pop_front();
                    chk("cdb_rob", {28'd0, rob_id_to_cdb}, {28'd0, e.rob});
                    chk("cdb_data", data_to_cdb, e.data);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_full", {31'd0, full_sign_to_ls}, 32'd0);
        chk("rst_mc_en", {31'd0, enable_sign_to_mc}, 32'd0);
        chk("rst_cdb_valid", {31'd0, valid_sign_to_cdb}, 32'd0);
        chk("rst_cdb_rob", {28'd0, rob_id_to_cdb}, 32'd0);
        chk("rst_addr", addr_to_mc, 32'd0);
        chk("rst_len", {29'd0, len_to_mc}, 32'd0);
        rst = 1'b0;
        tick();

        // LW: full high exactly cycles 1..4, mc valid in cycle 4
        push_mc(1'b0, 32'h0000_0100, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0100, 32'h0, 4'd3);
        chk("lw_full_c1", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        chk("lw_full_c2", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        chk("lw_full_c3", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        chk("lw_full_c4", {31'd0, full_sign_to_ls}, 32'd1);
        push_cdb(4'd3, 32'hDEAD_BEEF);
        mc_done(32'hDEAD_BEEF);
        chk("lw_full_c5", {31'd0, full_sign_to_ls}, 32'd0);
        chk("lw_cdb_valid_c5", {31'd0, valid_sign_to_cdb}, 32'd1);
        tick();
        chk("lw_cdb_pulse_end", {31'd0, valid_sign_to_cdb}, 32'd0);

        // Byte/half extension
        push_mc(1'b0, 32'h0000_0201, 32'h0, 3'd1);
        issue(OPNUM_LB, 32'h0000_0201, 32'h0, 4'd5);
        tick();
        push_cdb(4'd5, 32'hFFFF_FFF0);
        mc_done(32'h0000_00F0);
        push_mc(1'b0, 32'h0000_0202, 32'h0, 3'd1);
        issue(OPNUM_LBU, 32'h0000_0202, 32'h0, 4'd6);
        tick();
        push_cdb(4'd6, 32'h0000_00F0);
        mc_done(32'h0000_00F0);
        push_mc(1'b0, 32'h0000_0203, 32'h0, 3'd2);
        issue(OPNUM_LH, 32'h0000_0203, 32'h0, 4'd7);
        tick();
        push_cdb(4'd7, 32'hFFFF_8001);
        mc_done(32'h0000_8001);
        push_mc(1'b0, 32'h0000_0204, 32'h0, 3'd2);
        issue(OPNUM_LHU, 32'h0000_0204, 32'h0, 4'd8);
        tick();
        push_cdb(4'd8, 32'h0000_8001);
        mc_done(32'hFFFF_8001);

        // Stores: masked data, no broadcast, full drops after mc valid
        push_mc(1'b1, 32'h0003_0000, 32'h0000_0078, 3'd1);
        issue(OPNUM_SB, 32'h0003_0000, 32'h1234_5678, 4'd9);
        tick();
        chk("sb_full", {31'd0, full_sign_to_ls}, 32'd1);
        mc_done(32'h0);
        chk("sb_full_drop", {31'd0, full_sign_to_ls}, 32'd0);
        push_mc(1'b1, 32'h0003_0002, 32'h0000_5678, 3'd2);
        issue(OPNUM_SH, 32'h0003_0002, 32'h1234_5678, 4'd9);
        tick();
        mc_done(32'h0);
        push_mc(1'b1, 32'h0003_0004, 32'h1234_5678, 3'd4);
        issue(OPNUM_SW, 32'h0003_0004, 32'h1234_5678, 4'd9);
        tick();
        mc_done(32'h0);
        tick();

        // Rollback one cycle after LW issue: mc completes, result dropped
        push_mc(1'b0, 32'h0000_0300, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0300, 32'h0, 4'd2);
        rollback_sign_from_rob = 1'b1;
        tick();
        rollback_sign_from_rob = 1'b0;
        tick();
        chk("rb_full_wait", {31'd0, full_sign_to_ls}, 32'd1);
        mc_done(32'h0000_0077);
        chk("rb_full_drop", {31'd0, full_sign_to_ls}, 32'd0);
        chk("rb_no_cdb", {31'd0, valid_sign_to_cdb}, 32'd0);

        // Rollback coincident with SW enable: store accepted
        rollback_sign_from_rob = 1'b1;
        push_mc(1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 3'd4);
        issue(OPNUM_SW, 32'h0000_0400, 32'hA5A5_5A5A, 4'd4);
        rollback_sign_from_rob = 1'b0;
        chk("rb_sw_full", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        mc_done(32'h0);

        // Rollback coincident with LB enable: load ignored
        rollback_sign_from_rob = 1'b1;
        issue(OPNUM_LB, 32'h0000_0500, 32'h0, 4'd5);
        rollback_sign_from_rob = 1'b0;
        chk("rb_lb_full", {31'd0, full_sign_to_ls}, 32'd0);
        chk("rb_lb_mc_en", {31'd0, enable_sign_to_mc}, 32'd0);

        // Rollback coincident with mc valid suppresses the broadcast
        push_mc(1'b0, 32'h0000_0600, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0600, 32'h0, 4'd13);
        tick();
        rollback_sign_from_rob = 1'b1;
        mc_done(32'h0000_0055);
        rollback_sign_from_rob = 1'b0;
        chk("rb_valid_no_cdb", {31'd0, valid_sign_to_cdb}, 32'd0);
        chk("rb_valid_full", {31'd0, full_sign_to_ls}, 32'd0);

        // Back-to-back: SW issued in the cycle the LW result appears
        push_mc(1'b0, 32'h0000_0700, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0700, 32'h0, 4'd9);
        tick();
        push_cdb(4'd9, 32'h1357_9BDF);
        mc_done(32'h1357_9BDF);
        chk("b2b_full_free", {31'd0, full_sign_to_ls}, 32'd0);
        push_mc(1'b1, 32'h0000_0704, 32'h0246_8ACE, 3'd4);
        issue(OPNUM_SW, 32'h0000_0704, 32'h0246_8ACE, 4'd10);
        chk("b2b_sw_mc_en", {31'd0, enable_sign_to_mc}, 32'd1);
        tick();
        mc_done(32'h0);

        // rdy low for two cycles mid-WAIT_MC delays completion by two cycles
        push_mc(1'b0, 32'h0000_0800, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0800, 32'h0, 4'd10);
        tick();
        rdy = 1'b0;
        tick();
        chk("stall_full", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        chk("stall_mc_en", {31'd0, enable_sign_to_mc}, 32'd0);
        rdy = 1'b1;
        tick();
        tick();
        chk("stall_full_c6", {31'd0, full_sign_to_ls}, 32'd1);
        push_cdb(4'd10, 32'h0BAD_F00D);
        mc_done(32'h0BAD_F00D);
        chk("stall_cdb_c7", {31'd0, valid_sign_to_cdb}, 32'd1);
        chk("stall_full_c7", {31'd0, full_sign_to_ls}, 32'd0);

        // Async reset mid-WAIT_MC clears outputs at once
        push_mc(1'b0, 32'h0000_0900, 32'h0, 3'd4);
        issue(OPNUM_LW, 32'h0000_0900, 32'h0, 4'd11);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_full", {31'd0, full_sign_to_ls}, 32'd0);
        chk("arst_addr", addr_to_mc, 32'd0);
        chk("arst_len", {29'd0, len_to_mc}, 32'd0);
        chk("arst_cdb_rob", {28'd0, rob_id_to_cdb}, 32'd0);
        chk("arst_cdb_data", data_to_cdb, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push_mc(1'b1, 32'h0000_0040, 32'hCAFE_BABE, 3'd4);
        issue(OPNUM_SW, 32'h0000_0040, 32'hCAFE_BABE, 4'd12);
        chk("arst_reissue_full", {31'd0, full_sign_to_ls}, 32'd1);
        tick();
        mc_done(32'h0);
        chk("arst_reissue_done", {31'd0, full_sign_to_ls}, 32'd0);
        tick();
        tick();

        chk("mc_q_drained", mc_q.size(), 32'd0);
        chk("cdb_q_drained", cdb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
